bet_settle_unit: RTL and testbench

//  Parametrised successor to the fixed 8-bit bet/balance logic of the baccarat datapath.

---
 rtl/baccarat_pkg.sv | 28 ++
 rtl/bet_settle_unit_if.sv | 34 +++
 rtl/settle_payout.sv | 67 ++++++
 rtl/bet_settle_unit.sv | 174 +++++++++++++++++
 tb/tb_bet_settle_unit.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/baccarat_pkg.sv
// rtl/baccarat_pkg.sv - shared codes, FSM encoding and score limit for the bet/settle datapath
package baccarat_pkg;

  typedef enum logic [1:0] {
    BET_NONE   = 2'b00,
    BET_PLAYER = 2'b01,
    BET_DEALER = 2'b10,
    BET_TIE    = 2'b11
  } bet_type_e;

  typedef enum logic [1:0] {
    RES_NONE   = 2'b00,
    RES_PLAYER = 2'b01,
    RES_DEALER = 2'b10,
    RES_TIE    = 2'b11
  } result_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_CALC  = 2'b10,
    ST_APPLY = 2'b11
  } state_e;

  // Highest legal baccarat hand score.
  localparam logic [3:0] SCORE_MAX = 4'd9;

endpackage

// File: rtl/bet_settle_unit_if.sv
// rtl/bet_settle_unit_if.sv - bet handshake, settle request and balance/status bundle
interface bet_settle_unit_if #(
  parameter int BAL_W = 8,
  parameter int BET_W = 8
);

  logic             bet_valid;
  logic             bet_ready;
  logic [1:0]       bet_type;
  logic [BET_W-1:0] bet_amount;
  logic             bet_cancel;
  logic             settle_req;
  logic [3:0]       pscore;
  logic [3:0]       dscore;
  logic [BAL_W-1:0] balance;
  logic [1:0]       result;
  logic             settle_done;
  logic             bet_reject;
  logic             score_err;
  logic             sat_flag;

  // Game FSM / score datapath side.
  modport master (
    output bet_valid, bet_type, bet_amount, bet_cancel, settle_req, pscore, dscore,
    input  bet_ready, balance, result, settle_done, bet_reject, score_err, sat_flag
  );

  // Settle unit side.
  modport slave (
    input  bet_valid, bet_type, bet_amount, bet_cancel, settle_req, pscore, dscore,
    output bet_ready, balance, result, settle_done, bet_reject, score_err, sat_flag
  );

endinterface

// File: rtl/settle_payout.sv
// rtl/settle_payout.sv - combinational round classification and signed balance delta
module settle_payout
  import baccarat_pkg::*;
#(
  parameter int BET_W      = 8,
  parameter int DELTA_W    = 20,
  parameter int TIE_PAYOUT = 8
) (
  input  logic [3:0]                pscore,
  input  logic [3:0]                dscore,
  input  logic [1:0]                bet_type,
  input  logic [BET_W-1:0]          bet_amount,
  output logic [1:0]                result,
  output logic signed [DELTA_W-1:0] delta,
  output logic                      score_err
);

  logic signed [DELTA_W-1:0] amt;
  logic signed [DELTA_W-1:0] tie_win;
  logic [1:0]                outcome;

  // The delta is wide enough that TIE_PAYOUT*amount can never wrap.
  assign amt     = signed'(DELTA_W'(bet_amount));
  assign tie_win = amt * signed'(DELTA_W'(TIE_PAYOUT));

  // Classify the hand, then price the locked bet against that outcome.
  always_comb begin
    result    = RES_NONE;
    delta     = '0;
    score_err = 1'b0;
    outcome   = RES_NONE;
    if ((pscore > SCORE_MAX) || (dscore > SCORE_MAX)) begin
      // Corrupt score: refuse to move money and report no outcome.
      score_err = 1'b1;
    end else begin
      if (pscore > dscore) begin
        outcome = RES_PLAYER;
      end else if (pscore < dscore) begin
        outcome = RES_DEALER;
      end else begin
        outcome = RES_TIE;
      end
      result = outcome;
      case (bet_type)
        BET_PLAYER: begin
          if (outcome == RES_PLAYER) begin
            delta = amt;
          end else if (outcome == RES_DEALER) begin
            delta = -amt;
          end
        end
        BET_DEALER: begin
          if (outcome == RES_DEALER) begin
            delta = amt;
          end else if (outcome == RES_PLAYER) begin
            delta = -amt;
          end
        end
        BET_TIE: begin
          delta = (outcome == RES_TIE) ? tie_win : -amt;
        end
        default: delta = '0;
      endcase
    end
  end

endmodule

// File: rtl/bet_settle_unit.sv
// rtl/bet_settle_unit.sv - bet lock, settle FSM and saturating balance register
module bet_settle_unit
  import baccarat_pkg::*;
#(
  parameter int BAL_W        = 8,
  parameter int BET_W        = 8,
  parameter int INIT_BALANCE = 100,
  parameter int TIE_PAYOUT   = 8
) (
  input  logic             clock,
  input  logic             resetb,
  bet_settle_unit_if.slave bus
);

  localparam int DW = BAL_W + BET_W + 4;
  localparam logic [BAL_W-1:0] BAL_MAX  = {BAL_W{1'b1}};
  localparam logic [BAL_W-1:0] BAL_INIT = BAL_W'(INIT_BALANCE);

  state_e               state_q, state_d;
  logic [1:0]           bet_type_q, bet_type_d;
  logic [BET_W-1:0]     bet_amount_q, bet_amount_d;
  logic [3:0]           pscore_q, pscore_d;
  logic [3:0]           dscore_q, dscore_d;
  logic signed [DW-1:0] delta_q, delta_d;
  logic [1:0]           calc_res_q, calc_res_d;
  logic                 calc_err_q, calc_err_d;
  logic [BAL_W-1:0]     balance_q, balance_d;
  logic [1:0]           result_q, result_d;
  logic                 settle_done_q, settle_done_d;
  logic                 bet_reject_q, bet_reject_d;
  logic                 score_err_q, score_err_d;
  logic                 sat_flag_q, sat_flag_d;

  logic [1:0]           pay_res;
  logic signed [DW-1:0] pay_delta;
  logic                 pay_err;
  logic                 bet_ok;
  logic signed [DW-1:0] sum;
  logic [BAL_W-1:0]     clamped;
  logic                 clamp_hi;

  settle_payout #(
    .BET_W      (BET_W),
    .DELTA_W    (DW),
    .TIE_PAYOUT (TIE_PAYOUT)
  ) u_payout (
    .pscore     (pscore_q),
    .dscore     (dscore_q),
    .bet_type   (bet_type_q),
    .bet_amount (bet_amount_q),
    .result     (pay_res),
    .delta      (pay_delta),
    .score_err  (pay_err)
  );

  // A bet is only worth locking if it names a side, stakes something and is covered.
  assign bet_ok = (bus.bet_type != BET_NONE) && (bus.bet_amount != '0) &&
                  (BAL_W'(bus.bet_amount) <= balance_q);

  // New balance clamped to the register range; losses cannot exceed the covered stake.
  always_comb begin
    sum      = signed'(DW'(balance_q)) + delta_q;
    clamped  = sum[BAL_W-1:0];
    clamp_hi = 1'b0;
    if (sum[DW-1]) begin
      clamped = '0;
    end else if (sum > signed'(DW'(BAL_MAX))) begin
      clamped  = BAL_MAX;
      clamp_hi = 1'b1;
    end
  end

  // Round sequencing: lock bet, capture scores, price, then commit to the balance.
  always_comb begin
    state_d       = state_q;
    bet_type_d    = bet_type_q;
    bet_amount_d  = bet_amount_q;
    pscore_d      = pscore_q;
    dscore_d      = dscore_q;
    delta_d       = delta_q;
    calc_res_d    = calc_res_q;
    calc_err_d    = calc_err_q;
    balance_d     = balance_q;
    result_d      = result_q;
    settle_done_d = 1'b0;
    bet_reject_d  = 1'b0;
    score_err_d   = score_err_q;
    sat_flag_d    = sat_flag_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.bet_valid) begin
          if (bet_ok) begin
            bet_type_d   = bus.bet_type;
            bet_amount_d = bus.bet_amount;
            score_err_d  = 1'b0;
            sat_flag_d   = 1'b0;
            state_d      = ST_ARMED;
          end else begin
            bet_reject_d = 1'b1;
          end
        end
      end
      ST_ARMED: begin
        // Cancel takes priority so an abandoned round never touches the balance.
        if (bus.bet_cancel) begin
          state_d = ST_IDLE;
        end else if (bus.settle_req) begin
          pscore_d = bus.pscore;
          dscore_d = bus.dscore;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        delta_d    = pay_delta;
        calc_res_d = pay_res;
        calc_err_d = pay_err;
        state_d    = ST_APPLY;
      end
      ST_APPLY: begin
        balance_d     = clamped;
        result_d      = calc_res_q;
        settle_done_d = 1'b1;
        score_err_d   = score_err_q | calc_err_q;
        sat_flag_d    = sat_flag_q | clamp_hi;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any round in flight.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q       <= ST_IDLE;
      bet_type_q    <= '0;
      bet_amount_q  <= '0;
      pscore_q      <= '0;
      dscore_q      <= '0;
      delta_q       <= '0;
      calc_res_q    <= '0;
      calc_err_q    <= 1'b0;
      balance_q     <= BAL_INIT;
      result_q      <= '0;
      settle_done_q <= 1'b0;
      bet_reject_q  <= 1'b0;
      score_err_q   <= 1'b0;
      sat_flag_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      bet_type_q    <= bet_type_d;
      bet_amount_q  <= bet_amount_d;
      pscore_q      <= pscore_d;
      dscore_q      <= dscore_d;
      delta_q       <= delta_d;
      calc_res_q    <= calc_res_d;
      calc_err_q    <= calc_err_d;
      balance_q     <= balance_d;
      result_q      <= result_d;
      settle_done_q <= settle_done_d;
      bet_reject_q  <= bet_reject_d;
      score_err_q   <= score_err_d;
      sat_flag_q    <= sat_flag_d;
    end
  end

  assign bus.bet_ready   = (state_q == ST_IDLE);
  assign bus.balance     = balance_q;
  assign bus.result      = result_q;
  assign bus.settle_done = settle_done_q;
  assign bus.bet_reject  = bet_reject_q;
  assign bus.score_err   = score_err_q;
  assign bus.sat_flag    = sat_flag_q;

endmodule

// File: tb/tb_bet_settle_unit.sv
// tb/tb_bet_settle_unit.sv - directed bench with a round-level balance model for bet_settle_unit
module tb_bet_settle_unit;

  localparam int TIE = 8;
  localparam int MAXB = 255;
  localparam int INIT = 100;

  logic clock = 1'b0;
  logic resetb;

  bet_settle_unit_if #(.BAL_W(8), .BET_W(8)) bus ();

  bet_settle_unit #(
    .BAL_W        (8),
    .BET_W        (8),
    .INIT_BALANCE (INIT),
    .TIE_PAYOUT   (TIE)
  ) dut (
    .clock  (clock),
    .resetb (resetb),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Round-level model of what the unit must be showing.
  int m_balance, m_result, m_type, m_amt;
  bit m_armed, m_busy, m_done, m_reject, m_err, m_sat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_balance = INIT; m_result = 0; m_type = 0; m_amt = 0;
    m_armed = 0; m_busy = 0; m_done = 0; m_reject = 0; m_err = 0; m_sat = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    m_done   = 0;
    m_reject = 0;
  endtask

  task automatic model_apply(input int p, input int d);
    int delta, nb, outcome;
    delta = 0;
    if (p > 9 || d > 9) begin
      m_err = 1;
      m_result = 0;
    end else begin
      outcome = (p > d) ? 1 : ((p < d) ? 2 : 3);
      m_result = outcome;
      if (m_type == 3) delta = (outcome == 3) ? TIE * m_amt : -m_amt;
      else if (outcome == 3) delta = 0;
      else delta = (outcome == m_type) ? m_amt : -m_amt;
    end
    nb = m_balance + delta;
    if (nb > MAXB) begin
      nb = MAXB;
      m_sat = 1;
    end
    if (nb < 0) nb = 0;
    m_balance = nb;
  endtask

  task automatic offer(input logic [1:0] t, input int amt);
    bus.bet_valid = 1'b1; bus.bet_type = t; bus.bet_amount = 8'(amt);
    tick();
    if (!m_armed && !m_busy) begin
      if (t != 2'b00 && amt != 0 && amt <= m_balance) begin
        m_armed = 1; m_type = int'(t); m_amt = amt; m_err = 0; m_sat = 0;
      end else begin
        m_reject = 1;
      end
    end
    bus.bet_valid = 1'b0; bus.bet_type = 2'b00; bus.bet_amount = 8'd0;
  endtask

  task automatic settle(input int p, input int d);
    bus.settle_req = 1'b1; bus.pscore = 4'(p); bus.dscore = 4'(d);
    tick();
    bus.settle_req = 1'b0; bus.pscore = 4'hf; bus.dscore = 4'hf;
    if (m_armed) begin
      m_armed = 0; m_busy = 1;
      tick();
      tick();
      model_apply(p, d);
      m_busy = 0;
      m_done = 1;
    end
  endtask

  task automatic cancel(input bit with_settle);
    bus.bet_cancel = 1'b1; bus.settle_req = with_settle; bus.pscore = 4'd5; bus.dscore = 4'd2;
    tick();
    bus.bet_cancel = 1'b0; bus.settle_req = 1'b0;
    if (m_armed) m_armed = 0;
  endtask

  task automatic do_reset();
    resetb = 1'b0;
    model_reset();
    tick();
    tick();
    resetb = 1'b1;
  endtask

  // Every cycle the DUT outputs must match the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("bet_ready",   32'(bus.bet_ready),   32'((m_armed || m_busy) ? 0 : 1));
      check("balance",     32'(bus.balance),     32'(m_balance));
      check("result",      32'(bus.result),      32'(m_result));
      check("settle_done", 32'(bus.settle_done), 32'(m_done));
      check("bet_reject",  32'(bus.bet_reject),  32'(m_reject));
      check("score_err",   32'(bus.score_err),   32'(m_err));
      check("sat_flag",    32'(bus.sat_flag),    32'(m_sat));
    end
  end

  initial begin
    resetb = 1'b0;
    bus.bet_valid = 1'b0; bus.bet_type = 2'b00; bus.bet_amount = 8'd0;
    bus.bet_cancel = 1'b0; bus.settle_req = 1'b0; bus.pscore = 4'd0; bus.dscore = 4'd0;
    model_reset();
    tick();
    tick();
    resetb = 1'b1;
    chk_en = 1'b1;
    check("rst_balance", 32'(bus.balance), 32'd100);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_ready", 32'(bus.bet_ready), 32'd1);
    check("rst_flags", {30'd0, bus.sat_flag, bus.score_err}, 32'd0);

    // Player bet wins 1:1; done two edges after the request edge.
    offer(2'b01, 10);
    check("armed_ready", 32'(bus.bet_ready), 32'd0);
    settle(7, 5);
    check("pwin_bal", 32'(bus.balance), 32'd110);
    check("pwin_res", 32'(bus.result), 32'd1);
    check("pwin_done", 32'(bus.settle_done), 32'd1);
    settle(7, 5);
    check("idle_settle_ignored", 32'(bus.balance), 32'd110);

    // Tie bet pays TIE:1; player bet on a tie pushes.
    do_reset();
    offer(2'b11, 10);
    settle(6, 6);
    check("tie_bal", 32'(bus.balance), 32'd180);
    offer(2'b01, 10);
    settle(3, 3);
    check("push_bal", 32'(bus.balance), 32'd180);
    check("push_res", 32'(bus.result), 32'd3);

    // Refusals and the amount==balance boundary.
    do_reset();
    offer(2'b10, 120);
    check("over_reject", 32'(bus.bet_reject), 32'd1);
    check("over_ready", 32'(bus.bet_ready), 32'd1);
    offer(2'b00, 10);
    offer(2'b01, 0);
    offer(2'b10, 100);
    offer(2'b01, 5);
    check("armed_no_reject", 32'(bus.bet_reject), 32'd0);
    settle(2, 8);
    check("dwin_bal", 32'(bus.balance), 32'd200);
    offer(2'b01, 200);
    settle(1, 4);
    check("lose_all_bal", 32'(bus.balance), 32'd0);
    offer(2'b01, 1);
    check("broke_reject", 32'(bus.bet_reject), 32'd1);

    // Saturation, sticky flags and their clearing on the next accepted bet.
    do_reset();
    offer(2'b11, 10);
    settle(6, 6);
    offer(2'b01, 70);
    settle(9, 0);
    check("pre_sat_bal", 32'(bus.balance), 32'd250);
    offer(2'b11, 10);
    settle(4, 4);
    check("sat_bal", 32'(bus.balance), 32'd255);
    check("sat_flag", 32'(bus.sat_flag), 32'd1);
    offer(2'b10, 5);
    check("sat_cleared", 32'(bus.sat_flag), 32'd0);
    settle(12, 3);
    check("serr_flag", 32'(bus.score_err), 32'd1);
    check("serr_bal", 32'(bus.balance), 32'd255);
    check("serr_res", 32'(bus.result), 32'd0);
    offer(2'b01, 20);
    check("serr_cleared", 32'(bus.score_err), 32'd0);
    cancel(1'b0);
    check("cancel_ready", 32'(bus.bet_ready), 32'd1);
    offer(2'b10, 20);
    cancel(1'b1);
    tick();
    tick();
    tick();
    check("cancel_wins_bal", 32'(bus.balance), 32'd255);

    // Reset while pricing aborts the round.
    offer(2'b01, 10);
    bus.settle_req = 1'b1; bus.pscore = 4'd7; bus.dscore = 4'd1;
    tick();
    bus.settle_req = 1'b0;
    m_armed = 0; m_busy = 1;
    resetb = 1'b0;
    model_reset();
    tick();
    tick();
    check("rst_calc_done", 32'(bus.settle_done), 32'd0);
    check("rst_calc_bal", 32'(bus.balance), 32'd100);
    resetb = 1'b1;
    tick();
    offer(2'b10, 10);
    settle(3, 10);
    check("derr_flag", 32'(bus.score_err), 32'd1);
    check("derr_bal", 32'(bus.balance), 32'd100);
    tick();
    tick();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
